// File: rtl/branch_resolver.sv
// Branch resolver: registers ALU status flags and resolves conditional branches
// against them, returning taken/not-taken and the next PC over valid/ready handshakes.
module branch_resolver #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         res_valid,
    output logic         res_ready,
    input  logic [W-1:0] res_value,
    input  logic         res_carry,
    input  logic         res_ovf,
    input  logic         br_valid,
    output logic         br_ready,
    input  logic [2:0]   br_cond,
    input  logic [W-1:0] br_pc,
    input  logic [W-1:0] br_offset,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_taken,
    output logic [W-1:0] out_target,
    output logic [3:0]   flags_out,
    output logic         flags_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_EVAL = 2'b10,
        ST_OUT  = 2'b11
    } state_t;

    localparam logic [W-1:0] PC_STEP = {{(W-3){1'b0}}, 3'b100};

    state_t         state_r;
    state_t         state_next_s;
    logic [3:0]     flags_r;
    logic           flags_valid_r;
    logic [2:0]     cond_r;
    logic [W-1:0]   pc_r;
    logic [W-1:0]   offset_r;
    logic           out_valid_r;
    logic           out_taken_r;
    logic [W-1:0]   out_target_r;
    logic           res_xfer_s;
    logic           br_xfer_s;
    logic           taken_s;
    logic [W-1:0]   offset_bytes_s;
    logic [W-1:0]   target_s;

    // Flags are packed {Z,N,C,V}.
    function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] flags);
        logic z;
        logic n;
        logic c;
        logic v;
        logic met;
        z = flags[3];
        n = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            3'b000:  met = z;
            3'b001:  met = !z;
            3'b010:  met = n ^ v;
            3'b011:  met = !(n ^ v);
            3'b100:  met = !c;
            3'b101:  met = c;
            3'b110:  met = 1'b1;
            3'b111:  met = 1'b0;
            default: met = 1'b0;
        endcase
        return met;
    endfunction

    assign res_ready   = (state_r == ST_IDLE) || (state_r == ST_WAIT);
    assign br_ready    = (state_r == ST_IDLE);
    assign res_xfer_s  = res_valid && res_ready;
    // A branch arriving together with flush is dropped, not latched.
    assign br_xfer_s   = br_valid && br_ready && !flush;

    assign out_valid   = out_valid_r;
    assign out_taken   = out_taken_r;
    assign out_target  = out_target_r;
    assign flags_out   = flags_r;
    assign flags_valid = flags_valid_r;

    // Branch condition and target from the latched branch and registered flags.
    always_comb begin
        taken_s        = cond_met(cond_r, flags_r);
        offset_bytes_s = {offset_r[W-3:0], 2'b00};
        if (taken_s) begin
            target_s = pc_r + offset_bytes_s;
        end else begin
            target_s = pc_r + PC_STEP;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (br_xfer_s) begin
                        // A result landing this same edge supplies the flags used.
                        if (flags_valid_r || res_xfer_s) begin
                            state_next_s = ST_EVAL;
                        end else begin
                            state_next_s = ST_WAIT;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (res_xfer_s) begin
                        state_next_s = ST_EVAL;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end
                ST_EVAL: begin
                    state_next_s = ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_OUT;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Flag register; updates on every accepted result, flush included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_r       <= 4'b0000;
            flags_valid_r <= 1'b0;
        end else if (res_xfer_s) begin
            flags_r       <= {~|res_value, res_value[W-1], res_carry, res_ovf};
            flags_valid_r <= 1'b1;
        end else begin
            flags_r       <= flags_r;
            flags_valid_r <= flags_valid_r;
        end
    end

    // Latched branch fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cond_r   <= 3'b000;
            pc_r     <= {W{1'b0}};
            offset_r <= {W{1'b0}};
        end else if (br_xfer_s) begin
            cond_r   <= br_cond;
            pc_r     <= br_pc;
            offset_r <= br_offset;
        end else begin
            cond_r   <= cond_r;
            pc_r     <= pc_r;
            offset_r <= offset_r;
        end
    end

    // Resolution output registers, held stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_taken_r  <= 1'b0;
            out_target_r <= {W{1'b0}};
        end else if (flush) begin
            out_valid_r  <= 1'b0;
            out_taken_r  <= out_taken_r;
            out_target_r <= out_target_r;
        end else if (state_r == ST_EVAL) begin
            out_valid_r  <= 1'b1;
            out_taken_r  <= taken_s;
            out_target_r <= target_s;
        end else if ((state_r == ST_OUT) && out_ready) begin
            out_valid_r  <= 1'b0;
            out_taken_r  <= out_taken_r;
            out_target_r <= out_target_r;
        end else begin
            out_valid_r  <= out_valid_r;
            out_taken_r  <= out_taken_r;
            out_target_r <= out_target_r;
        end
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumer side of the ALU status path: accepts ALU results, derives and registers zero/negative/carry/overflow flags, and resolves conditional branch requests against those flags.
- Sits between the adder/ALU datapath and the fetch stage.
- Produces a taken/not-taken decision and the next PC over valid/ready handshakes.
- Multi-cycle: a branch waits for valid flags, is evaluated, then held until the consumer accepts it.

Parameters:
- W, 32, datapath and PC width in bits (W >= 4).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- flush  input  1  synchronous abort of any in-flight branch
- res_valid  input  1  ALU result present
- res_ready  output  1  resolver accepts ALU result
- res_value  input  W  ALU result value
- res_carry  input  1  carry out of ALU (a-b: 1 = no borrow)
- res_ovf  input  1  signed overflow of ALU
- br_valid  input  1  branch request present
- br_ready  output  1  resolver accepts branch request
- br_cond  input  3  condition code
- br_pc  input  W  PC of branch instruction
- br_offset  input  W  signed word offset
- out_valid  output  1  resolution present
- out_ready  input  1  consumer accepts resolution
- out_taken  output  1  branch taken
- out_target  output  W  next PC
- flags_out  output  4  registered {Z,N,C,V}
- flags_valid  output  1  flags_out holds a result since reset

Behaviour:
- Reset (rst_n=0 at edge): state IDLE, flags_out=0, flags_valid=0, out_valid=0, out_taken=0, out_target=0, latched branch fields 0. rst_n dominates flush and all handshakes.
- Handshake: transfer occurs when valid&&ready at a rising edge. out_valid, out_taken and out_target stay stable while out_valid=1 and out_ready=0.
- Flag update on result transfer, visible the next cycle:
  - Z = (res_value == 0), reduced over all W bits.
  - N = res_value[W-1].
  - C = res_carry; V = res_ovf.
  - flags_valid set to 1.
- res_ready = 1 in IDLE and WAIT, 0 in EVAL and OUT. Flags are frozen while a branch is being evaluated or held.
- br_ready = 1 only in IDLE.
- State IDLE:
  - On branch transfer, latch cond, pc and offset.
  - Go to EVAL if flags_valid will be 1 after this edge (already 1, or a result transfers in the same cycle); otherwise go to WAIT.
  - A result transferring in the same cycle as the branch is the flag set the branch uses.
- State WAIT: on result transfer go to EVAL; otherwise stay.
- State EVAL (one cycle): compute taken from the registered flags, then go to OUT with out_valid=1.
- Condition codes:
  - 000 EQ: Z
  - 001 NE: !Z
  - 010 LT: N^V
  - 011 GE: !(N^V)
  - 100 LTU: !C
  - 101 GEU: C
  - 110 ALWAYS: 1
  - 111 NEVER: 0
- Target:
  - Taken: pc + (offset << 2).
  - Not taken: pc + 4.
  - Both computed modulo 2^W; wrap-around is silent and the upper carry is discarded.
- State OUT: on out_ready=1, clear out_valid and return to IDLE. br_ready rises the following cycle (no same-cycle re-accept).
- Latency: branch accepted in IDLE with valid flags gives out_valid=1 two cycles after acceptance. From WAIT, out_valid=1 two cycles after the result transfer.
- flush=1 at an edge (rst_n=1):
  - State goes to IDLE and out_valid clears.
  - Any branch transferring that same cycle is dropped.
  - Flags are preserved, and a result transferring that cycle still updates them.
- Back-to-back results in IDLE/WAIT overwrite flags each cycle; the last one before EVAL wins.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with br_valid=1, res_valid=1 -> flags_out=0, flags_valid=0, out_valid=0. After release, br_ready=1 and res_ready=1.
- EQ taken: result 0x00000000 transfers, then branch cond=000, pc=0x100, offset=0x4 -> out_valid 2 cycles later, out_taken=1, out_target=0x110. With out_ready=1, IDLE the next cycle.
- Wait path: branch cond=001 with flags_valid=0 -> stays in WAIT, br_ready=0. Result 0x5 transfers -> out_taken=1, out_target=pc+0x10 when offset=4. Repeat with result 0 -> out_taken=0, out_target=pc+4.
- Same-cycle result and branch: flags Z=0, then result 0 and branch EQ transfer together -> resolution uses Z=1, out_taken=1.
- Signed/unsigned compare plus wrap: res_carry=0, res_ovf=0, N=1 with cond LT and LTU -> both taken. pc=0xFFFFFFFC, not taken -> out_target=0x00000000. Taken with offset=0xFFFFFFFF (-1) -> target=pc-4.
- Backpressure and flush: out_ready=0 for 5 cycles -> outputs stable, res_ready=0, a result presented then does not transfer. Assert flush -> out_valid=0 next cycle, flags unchanged, br_ready=1.
